flash16_wb_master: RTL and testbench
====================================

Name: flash16_wb_master

Overview:
- Wishbone slave to parallel 16-bit NOR flash bridge.
- Turns each 32-bit bus read into two sequential 16-bit flash reads, upper half first.
- Turns each bus write into one or two 16-bit flash write strobes.
- Sits between the system bus and the flash_adr / flash_d / flash_we_n pins. It drives the same interface the board flash model answers, with big-endian half ordering: flash_adr[1]=0 carries bits 31:16.

Parameters:
- ADR_WIDTH, 24: flash byte-address width.
- RD_TIMING, 4: sys_clk cycles each half-word read address is held. Minimum 2.
- WR_TIMING, 6: sys_clk cycles flash_we_n is held low per half-word write. Minimum 1.

Ports:
- sys_clk  in  1  system clock; all state changes on rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- wb_adr_i  in  32  byte address; bits [ADR_WIDTH-1:2] used.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_sel_i  in  4  byte selects.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  1 = write.
- wb_ack_o  out  1  single-cycle acknowledge.
- flash_adr  out  ADR_WIDTH  byte address to flash; bit 0 always 0.
- flash_d_i  in  16  data from flash pins.
- flash_d_o  out  16  data to flash pins.
- flash_d_oe  out  1  1 = drive flash_d_o onto pins.
- flash_oe_n  out  1  flash output enable, active-low.
- flash_we_n  out  1  flash write enable, active-low.
- flash_ce_n  out  1  flash chip enable, active-low.

Behaviour:
- Reset values (asynchronous):
  - wb_ack_o=0, wb_dat_o=0, flash_adr=0, flash_d_o=0, flash_d_oe=0.
  - flash_oe_n=1, flash_we_n=1, flash_ce_n=1.
  - State=IDLE.
  - Reset asserted mid-access aborts immediately; no ack is issued.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE:
  - Request accepted when wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_adr_i, wb_dat_i, wb_sel_i and wb_we_i are latched on acceptance.
  - half counter is set to 0 (upper half).
- Addressing:
  - flash_adr = {latched adr[ADR_WIDTH-1:2], half, 1'b0}.
  - It is registered and updated on the same edge as the state change.
- Read:
  - RD lasts RD_TIMING cycles per half, with flash_ce_n=0 and flash_oe_n=0.
  - flash_d_i is sampled on the last RD cycle of each half.
  - half 0 result goes to wb_dat_o[31:16]; half 1 result goes to wb_dat_o[15:0].
  - After half 1, move to ACK.
  - wb_ack_o rises exactly 2*RD_TIMING+1 cycles after the accept edge.
  - wb_dat_o is stable while wb_ack_o=1.
- Write:
  - Half 0 is written if wb_sel_i[3:2]!=0, using wb_dat_i[31:16].
  - Half 1 is written if wb_sel_i[1:0]!=0, using wb_dat_i[15:0].
  - Halves not selected are skipped.
  - Each written half runs WR_SETUP (1 cycle) → WR_PULSE (WR_TIMING cycles, flash_we_n=0) → WR_HOLD (1 cycle).
  - Throughout those cycles: flash_ce_n=0, flash_oe_n=1, flash_d_oe=1, flash_d_o stable.
  - flash_adr and flash_d_o never change while flash_we_n=0.
  - flash_d_oe is never 1 while flash_oe_n=0.
  - Write with wb_sel_i=0000: no flash activity; ack on the cycle after accept.
- ACK:
  - wb_ack_o=wb_cyc_i for exactly one cycle, then IDLE.
  - flash_ce_n returns to 1 in ACK.
  - ack never stays high two consecutive cycles, so back-to-back requests see ack low for at least 1 cycle.
- Abandoned cycle: if wb_cyc_i drops mid-transaction, the flash sequence still completes (writes never truncated) and the ack is suppressed.
- Changes to wb_adr_i or wb_dat_i after acceptance are ignored.

Test Plan:
- RD_TIMING=4; flash model holds 32'h1234ABCD at byte 0x100; bus read 0x100 → flash_adr 0x100 for 4 cycles then 0x102 for 4 cycles; wb_ack_o at cycle 9 after accept; wb_dat_o=32'h1234ABCD.
- Write 32'hDEAD_BEEF, sel=1111, adr 0x200, WR_TIMING=6 → two 6-cycle flash_we_n low pulses: 0x200/16'hDEAD then 0x202/16'hBEEF. Ack at cycle 17. Check setup/hold stability.
- Write with sel=0011 → single pulse at adr+2 with the lower data. sel=0000 → no flash_we_n activity, ack 1 cycle after accept.
- Two back-to-back reads with stb held high → exactly two ack pulses separated by a full second access, each with its own correct data.
- Assert sys_rst during WR_PULSE → flash_we_n=1, flash_d_oe=0 and flash_ce_n=1 before the next clock edge; no ack. The next read after reset is correct.
- Drop wb_cyc_i during the first read half → no ack; the FSM returns to IDLE after 2*RD_TIMING+1 cycles; the next request is served normally.

Source files
------------

// File: rtl/flash16_wb_master.sv
// flash16_wb_master: Wishbone slave bridging 32-bit bus accesses onto a
// 16-bit parallel NOR flash. Each bus read becomes two half-word reads
// (upper half at the lower flash address). Each bus write becomes one or two
// half-word write strobes, selected by the byte selects.
module flash16_wb_master #(
  parameter int ADR_WIDTH = 24,
  parameter int RD_TIMING = 4,
  parameter int WR_TIMING = 6
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  output logic [ADR_WIDTH-1:0] flash_adr,
  input  logic [15:0]          flash_d_i,
  output logic [15:0]          flash_d_o,
  output logic                 flash_d_oe,
  output logic                 flash_oe_n,
  output logic                 flash_we_n,
  output logic                 flash_ce_n
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    ACK      = 3'd5
  } state_t;

  // Terminal values of the per-half cycle counter.
  localparam logic [15:0] RD_LAST = 16'(RD_TIMING - 1);
  localparam logic [15:0] WR_LAST = 16'(WR_TIMING - 1);

  state_t               state;
  logic [15:0]          cnt;
  logic                 half;
  logic [ADR_WIDTH-3:0] adr_q;
  logic [15:0]          dat_lo;
  logic [1:0]           sel_lo;

  // Address bits outside the flash word range are intentionally ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:ADR_WIDTH], wb_adr_i[1:0]};

  // Flash byte address for a given word and half; bit 0 is always zero.
  function automatic logic [ADR_WIDTH-1:0] half_adr(
    input logic [ADR_WIDTH-3:0] word,
    input logic                 h
  );
    return {word, h, 1'b0};
  endfunction

  // Whether any byte lane of a half-word is selected.
  function automatic logic lanes_hit(input logic [1:0] sel);
    return (sel != 2'b00);
  endfunction

  // Main FSM: accepts a request, sequences the flash pins, and issues the ack.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      half       <= 1'b0;
      adr_q      <= '0;
      dat_lo     <= 16'h0000;
      sel_lo     <= 2'b00;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 32'h0000_0000;
      flash_adr  <= '0;
      flash_d_o  <= 16'h0000;
      flash_d_oe <= 1'b0;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
      flash_ce_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
            adr_q  <= wb_adr_i[ADR_WIDTH-1:2];
            dat_lo <= wb_dat_i[15:0];
            sel_lo <= wb_sel_i[1:0];
            cnt    <= 16'd0;
            half   <= 1'b0;
            if (!wb_we_i) begin
              state      <= RD;
              flash_adr  <= half_adr(wb_adr_i[ADR_WIDTH-1:2], 1'b0);
              flash_ce_n <= 1'b0;
              flash_oe_n <= 1'b0;
            end else if (lanes_hit(wb_sel_i[3:2])) begin
              state      <= WR_SETUP;
              flash_adr  <= half_adr(wb_adr_i[ADR_WIDTH-1:2], 1'b0);
              flash_d_o  <= wb_dat_i[31:16];
              flash_d_oe <= 1'b1;
              flash_ce_n <= 1'b0;
            end else if (lanes_hit(wb_sel_i[1:0])) begin
              // Upper half skipped: go straight to the lower half.
              state      <= WR_SETUP;
              half       <= 1'b1;
              flash_adr  <= half_adr(wb_adr_i[ADR_WIDTH-1:2], 1'b1);
              flash_d_o  <= wb_dat_i[15:0];
              flash_d_oe <= 1'b1;
              flash_ce_n <= 1'b0;
            end else begin
              // Nothing selected: acknowledge without touching the flash.
              state <= ACK;
            end
          end else begin
            state <= IDLE;
          end
        end

        RD: begin
          if (cnt == RD_LAST) begin
            cnt <= 16'd0;
            if (!half) begin
              wb_dat_o[31:16] <= flash_d_i;
              half            <= 1'b1;
              flash_adr       <= half_adr(adr_q, 1'b1);
            end else begin
              wb_dat_o[15:0] <= flash_d_i;
              state          <= ACK;
              flash_ce_n     <= 1'b1;
              flash_oe_n     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WR_SETUP: begin
          state      <= WR_PULSE;
          cnt        <= 16'd0;
          flash_we_n <= 1'b0;
        end

        WR_PULSE: begin
          if (cnt == WR_LAST) begin
            state      <= WR_HOLD;
            flash_we_n <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WR_HOLD: begin
          if (!half && lanes_hit(sel_lo)) begin
            state     <= WR_SETUP;
            half      <= 1'b1;
            flash_adr <= half_adr(adr_q, 1'b1);
            flash_d_o <= dat_lo;
          end else begin
            state      <= ACK;
            flash_ce_n <= 1'b1;
            flash_d_oe <= 1'b0;
          end
        end

        ACK: begin
          // Ack is suppressed if the master abandoned the cycle.
          wb_ack_o <= wb_cyc_i;
          state    <= IDLE;
        end

        default: begin
          state      <= IDLE;
          wb_ack_o   <= 1'b0;
          flash_ce_n <= 1'b1;
          flash_oe_n <= 1'b1;
          flash_we_n <= 1'b1;
          flash_d_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash16_wb_master.sv
// Testbench for flash16_wb_master: a half-word flash model, directed bus
// transactions, and a scoreboard monitor checking acks, read data, latency,
// and every flash write pulse.
module tb_flash16_wb_master;

  localparam int RDT = 4;
  localparam int WRT = 6;

  logic        sys_clk;
  logic        sys_rst;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic [23:0] flash_adr;
  logic [15:0] flash_d_i;
  logic [15:0] flash_d_o;
  logic        flash_d_oe;
  logic        flash_oe_n;
  logic        flash_we_n;
  logic        flash_ce_n;

  flash16_wb_master #(.ADR_WIDTH(24), .RD_TIMING(RDT), .WR_TIMING(WRT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .flash_adr(flash_adr), .flash_d_i(flash_d_i), .flash_d_o(flash_d_o),
    .flash_d_oe(flash_d_oe), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_ce_n(flash_ce_n)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [23:0] adr;
    logic [15:0] data;
  } wr_t;

  ack_t        exp_ack[$];
  wr_t         exp_wr[$];
  logic [15:0] mem [int];
  int          cyc_cnt = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Edge counter: at a negedge it equals the number of posedges so far.
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] mem_rd(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'h0000;
  endfunction

  // Flash model: drives read data while chip and output are enabled.
  always @(negedge sys_clk)
    flash_d_i <= (!flash_ce_n && !flash_oe_n) ? mem_rd(flash_adr) : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: acks against the expected-ack queue, write pulses against the
  // expected-write queue, plus pin-level invariants.
  initial begin
    int          low_cnt = 0;
    logic [23:0] p_adr = 24'h0;
    logic [15:0] p_dat = 16'h0;
    logic        prev_ack = 1'b0;
    ack_t        a;
    wr_t         w;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        low_cnt  = 0;
        prev_ack = 1'b0;
      end else begin
        if (wb_ack_o) begin
          chk("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
          if (exp_ack.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
          end else begin
            a = exp_ack.pop_front();
            chk("ack_latency", cyc_cnt, a.cyc);
            if (a.is_rd) chk("read_data", wb_dat_o, a.data);
          end
        end
        prev_ack = wb_ack_o;
        if (!flash_oe_n) chk("no_drive_while_oe", {31'd0, flash_d_oe}, 32'd0);
        if (!flash_we_n) begin
          if (low_cnt > 0) begin
            chk("adr_stable_in_pulse", {8'd0, flash_adr}, {8'd0, p_adr});
            chk("data_stable_in_pulse", {16'd0, flash_d_o}, {16'd0, p_dat});
          end
          chk("pins_in_pulse", {29'd0, flash_d_oe, flash_ce_n, flash_oe_n}, 32'd5);
          p_adr = flash_adr;
          p_dat = flash_d_o;
          low_cnt++;
        end else if (low_cnt > 0) begin
          chk("we_pulse_width", low_cnt, WRT);
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
          end else begin
            w = exp_wr.pop_front();
            chk("write_adr", {8'd0, p_adr}, {8'd0, w.adr});
            chk("write_data", {16'd0, p_dat}, {16'd0, w.data});
          end
          mem[int'(p_adr)] = p_dat;
          low_cnt = 0;
        end
      end
    end
  end

  task automatic wait_ack();
    int n = 0;
    while (!wb_ack_o && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    if (!wb_ack_o) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // Bus read; the address/data inputs are scrambled after acceptance.
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int lat);
    wb_adr_i = a; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    exp_ack.push_back('{1'b1, exp, cyc_cnt + 1 + lat});
    @(negedge sys_clk);
    wb_adr_i = 32'h00FF_FFFC; wb_dat_i = 32'h0BAD_F00D;
    wait_ack();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] sel, input int lat);
    wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    exp_ack.push_back('{1'b0, 32'h0, cyc_cnt + 1 + lat});
    @(negedge sys_clk);
    wb_adr_i = 32'h00FF_FFFC; wb_dat_i = 32'h0BAD_F00D; wb_sel_i = 4'h0;
    wait_ack();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    int acc;
    mem[32'h100] = 16'h1234; mem[32'h102] = 16'hABCD;
    mem[32'h300] = 16'hCAFE; mem[32'h302] = 16'hF00D;
    mem[32'h400] = 16'h0123; mem[32'h402] = 16'h4567;
    sys_rst = 1'b1;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;

    // Reset values.
    #12;
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_adr", {8'd0, flash_adr}, 32'd0);
    chk("rst_d_o", {16'd0, flash_d_o}, 32'd0);
    chk("rst_ctl", {28'd0, flash_d_oe, flash_oe_n, flash_we_n, flash_ce_n}, 32'h7);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Basic read.
    do_read(32'h100, 32'h1234_ABCD, 9);

    // Full write then read back.
    exp_wr.push_back('{24'h200, 16'hDEAD});
    exp_wr.push_back('{24'h202, 16'hBEEF});
    do_write(32'h200, 32'hDEAD_BEEF, 4'b1111, 17);
    do_read(32'h200, 32'hDEAD_BEEF, 9);

    // Lower half only.
    exp_wr.push_back('{24'h202, 16'h2222});
    do_write(32'h200, 32'h1111_2222, 4'b0011, 9);
    do_read(32'h200, 32'hDEAD_2222, 9);

    // No lanes selected: no flash activity, ack one edge after accept.
    do_write(32'h200, 32'h9999_9999, 4'b0000, 1);
    do_read(32'h200, 32'hDEAD_2222, 9);

    // Upper half only.
    exp_wr.push_back('{24'h204, 16'h5A5A});
    do_write(32'h204, 32'h5A5A_C3C3, 4'b1100, 9);
    do_read(32'h204, 32'h5A5A_0000, 9);

    // Back-to-back reads with strobe held; address changed after first accept.
    wb_adr_i = 32'h300; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acc = cyc_cnt + 1;
    exp_ack.push_back('{1'b1, 32'hCAFE_F00D, acc + 9});
    exp_ack.push_back('{1'b1, 32'h0123_4567, acc + 20});
    @(negedge sys_clk);
    wb_adr_i = 32'h400;
    wait_ack();
    @(negedge sys_clk);
    wait_ack();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sys_clk);

    // Reset during the write pulse: pins released at once, no ack, no write.
    wb_adr_i = 32'h500; wb_dat_i = 32'h7777_0000; wb_we_i = 1'b1; wb_sel_i = 4'b1100;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acc = cyc_cnt + 1;
    while (cyc_cnt < acc + 3) @(negedge sys_clk);
    chk("in_pulse_before_rst", {31'd0, flash_we_n}, 32'd0);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_mid_we_n", {31'd0, flash_we_n}, 32'd1);
    chk("rst_mid_d_oe", {31'd0, flash_d_oe}, 32'd0);
    chk("rst_mid_ce_n", {31'd0, flash_ce_n}, 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    do_read(32'h100, 32'h1234_ABCD, 9);

    // Abandoned read: no ack, FSM idle again exactly 2*RD+1 edges later.
    wb_adr_i = 32'h100; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acc = cyc_cnt + 1;
    @(negedge sys_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    while (cyc_cnt < acc + 9) @(negedge sys_clk);
    chk("abandon_ce_released", {31'd0, flash_ce_n}, 32'd1);
    do_read(32'h300, 32'hCAFE_F00D, 9);

    repeat (5) @(negedge sys_clk);
    chk("acks_outstanding", exp_ack.size(), 32'd0);
    chk("writes_outstanding", exp_wr.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
